// File: rtl/dp_tb_pkg.sv
// Shared definitions for the datapath result collector: FSM encoding,
// MISR defaults, rd_data layout and the signature step function.
package dp_tb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } state_e;

    localparam logic [31:0] MISR_POLY_DEF = 32'h04C11DB7;
    localparam logic [31:0] MISR_SEED_DEF = 32'hFFFFFFFF;

    // rd_data is {zero, outputs}: the zero flag sits just above the data bits.
    function automatic int zero_bit_pos(input int data_w);
        return data_w;
    endfunction

    function automatic logic [31:0] misr_step(
        input logic [31:0] sig,
        input logic [31:0] data,
        input logic [31:0] poly
    );
        logic [31:0] shifted;
        shifted = {sig[30:0], 1'b0} ^ (sig[31] ? poly : 32'd0);
        return shifted ^ data;
    endfunction

endpackage

// File: rtl/dp_result_fifo.sv
// Synchronous show-ahead FIFO with flush; rd_data reads 0 while empty.
module dp_result_fifo #(
    parameter int WIDTH = 33,
    parameter int DEPTH = 8
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wr_data,
    output logic [WIDTH-1:0]           rd_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_q == DEPTH_C);
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign rd_data = empty ? '0 : mem[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointers are log2(DEPTH) bits wide, so the increment wraps modulo DEPTH.
            if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + (AW+1)'(1);
                2'b01:   count_d = count_q - (AW+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage has no reset; validity is tracked by count, so stale words are never exposed.
    always_ff @(posedge CLK) begin
        if (push_ok && !flush) mem[wr_ptr_q] <= wr_data;
    end

endmodule

// File: rtl/dp_result_collector.sv
// Flow-controlled sink for datapath results: buffers beats in a FIFO and
// keeps a MISR signature, result/zero counts and a done indication.
module dp_result_collector
    import dp_tb_pkg::*;
#(
    parameter int          DATA_W    = 32,
    parameter int          DEPTH     = 8,
    parameter int          CNT_W     = 16,
    parameter logic [31:0] MISR_POLY = MISR_POLY_DEF,
    parameter logic [31:0] MISR_SEED = MISR_SEED_DEF
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      start,
    input  logic [CNT_W-1:0]          expected_cnt,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DATA_W-1:0]         outputs,
    input  logic                      zero,
    input  logic                      rd_en,
    output logic                      rd_valid,
    output logic [DATA_W:0]           rd_data,
    output logic [$clog2(DEPTH):0]    fifo_count,
    output logic [CNT_W-1:0]          result_cnt,
    output logic [CNT_W-1:0]          zero_cnt,
    output logic [31:0]               signature,
    output logic                      done,
    output logic                      underflow
);

    localparam int ZB = zero_bit_pos(DATA_W);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] exp_q, exp_d;
    logic [CNT_W-1:0] result_cnt_q, result_cnt_d;
    logic [CNT_W-1:0] zero_cnt_q, zero_cnt_d;
    logic [31:0]      sig_q, sig_d;
    logic             underflow_q, underflow_d;

    logic             fifo_full;
    logic             fifo_empty;
    logic             reached;
    logic             accept;
    logic [DATA_W:0]  push_word;
    logic [31:0]      data_ext;

    assign reached  = (result_cnt_q == exp_q);
    // Registered count only: a pop in a full cycle cannot open in_ready early.
    assign in_ready = (state_q == ST_COLLECT) && !fifo_full && !reached;
    assign accept   = in_valid && in_ready && !start;
    assign data_ext = 32'(outputs);

    always_comb begin
        push_word     = '0;
        push_word[ZB] = zero;
        push_word[DATA_W-1:0] = outputs;
    end

    dp_result_fifo #(
        .WIDTH (DATA_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK     (CLK),
        .RST     (RST),
        .flush   (start),
        .push    (accept),
        .pop     (rd_en),
        .wr_data (push_word),
        .rd_data (rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        exp_d        = exp_q;
        result_cnt_d = result_cnt_q;
        zero_cnt_d   = zero_cnt_q;
        sig_d        = sig_q;
        underflow_d  = underflow_q | (rd_en && fifo_empty);

        if (start) begin
            exp_d        = expected_cnt;
            result_cnt_d = '0;
            zero_cnt_d   = '0;
            sig_d        = MISR_SEED;
            underflow_d  = 1'b0;
        end else if (accept) begin
            if (result_cnt_q != '1)         result_cnt_d = result_cnt_q + CNT_W'(1);
            if (zero && zero_cnt_q != '1)   zero_cnt_d   = zero_cnt_q + CNT_W'(1);
            sig_d = misr_step(sig_q, data_ext, MISR_POLY);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_COLLECT;
            end
            ST_COLLECT: begin
                // Covers both the final accepted beat and expected_cnt = 0.
                if (!start && result_cnt_d == exp_q) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (start) state_d = ST_COLLECT;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            exp_q        <= '0;
            result_cnt_q <= '0;
            zero_cnt_q   <= '0;
            sig_q        <= MISR_SEED;
            underflow_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            exp_q        <= exp_d;
            result_cnt_q <= result_cnt_d;
            zero_cnt_q   <= zero_cnt_d;
            sig_q        <= sig_d;
            underflow_q  <= underflow_d;
        end
    end

    assign rd_valid   = !fifo_empty;
    assign result_cnt = result_cnt_q;
    assign zero_cnt   = zero_cnt_q;
    assign signature  = sig_q;
    assign done       = (state_q == ST_DONE);
    assign underflow  = underflow_q;

endmodule

// File: tb/tb_dp_result_collector.sv
// Directed bench for dp_result_collector: one task per scenario, inline checks.
module tb_dp_result_collector;

    logic        CLK = 1'b0;
    logic        RST;
    logic        start;
    logic [15:0] expected_cnt;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] outputs;
    logic        zero;
    logic        rd_en;
    logic        rd_valid;
    logic [32:0] rd_data;
    logic [3:0]  fifo_count;
    logic [15:0] result_cnt;
    logic [15:0] zero_cnt;
    logic [31:0] signature;
    logic        done;
    logic        underflow;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    dp_result_collector dut (
        .CLK          (CLK),
        .RST          (RST),
        .start        (start),
        .expected_cnt (expected_cnt),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .outputs      (outputs),
        .zero         (zero),
        .rd_en        (rd_en),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .fifo_count   (fifo_count),
        .result_cnt   (result_cnt),
        .zero_cnt     (zero_cnt),
        .signature    (signature),
        .done         (done),
        .underflow    (underflow)
    );

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_start(input logic [15:0] cnt);
        expected_cnt = cnt;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1; start = 1'b1; in_valid = 1'b1; rd_en = 1'b0;
        outputs = 32'hDEADBEEF; zero = 1'b1; expected_cnt = 16'd5;
        tick(); tick();
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
        n_checks++; if (signature !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL reset_sig: got %h want ffffffff", signature); end
        n_checks++; if (result_cnt !== 16'd0 || zero_cnt !== 16'd0 || fifo_count !== 4'd0) begin
            n_fail++; $display("FAIL reset_counts: got %0d/%0d/%0d want 0/0/0", result_cnt, zero_cnt, fifo_count); end
        n_checks++; if ({rd_valid, done, underflow} !== 3'b000 || rd_data !== 33'd0) begin
            n_fail++; $display("FAIL reset_flags: got %b%b%b data %h want 000 data 0", rd_valid, done, underflow, rd_data); end
        RST = 1'b0; start = 1'b0;
        tick(); tick();
        n_checks++; if (in_ready !== 1'b0 || result_cnt !== 16'd0 || fifo_count !== 4'd0) begin
            n_fail++; $display("FAIL idle_ignores_beat: got rdy %b cnt %0d fifo %0d want 0/0/0", in_ready, result_cnt, fifo_count); end
        in_valid = 1'b0; zero = 1'b0;
    endtask

    task automatic test_single();
        do_start(16'd1);
        n_checks++; if (in_ready !== 1'b1 || done !== 1'b0) begin
            n_fail++; $display("FAIL single_collect: got rdy %b done %b want 1/0", in_ready, done); end
        in_valid = 1'b1; outputs = 32'h00000001; zero = 1'b0;
        tick();
        in_valid = 1'b0;
        n_checks++; if (signature !== 32'hFB3EE248) begin n_fail++; $display("FAIL single_sig: got %h want fb3ee248", signature); end
        n_checks++; if (result_cnt !== 16'd1 || done !== 1'b1 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL single_done: got cnt %0d done %b rdy %b want 1/1/0", result_cnt, done, in_ready); end
        n_checks++; if (rd_data !== 33'h0_00000001 || rd_valid !== 1'b1) begin
            n_fail++; $display("FAIL single_head: got %h v %b want 000000001 v 1", rd_data, rd_valid); end
        rd_en = 1'b1; tick(); rd_en = 1'b0;
        n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL single_drain: got rd_valid %b want 0", rd_valid); end
    endtask

    task automatic test_backpressure();
        int acc;
        logic took;
        logic [32:0] want;
        acc = 0;
        do_start(16'd20);
        in_valid = 1'b1; outputs = 32'd100; zero = 1'b0;
        for (int c = 0; c < 10; c++) begin
            took = in_ready;
            tick();
            if (took) begin acc++; outputs = 32'(100 + acc); end
        end
        n_checks++; if (acc != 8) begin n_fail++; $display("FAIL bp_accepts: got %0d want 8", acc); end
        n_checks++; if (fifo_count !== 4'd8 || in_ready !== 1'b0 || result_cnt !== 16'd8) begin
            n_fail++; $display("FAIL bp_full: got fifo %0d rdy %b cnt %0d want 8/0/8", fifo_count, in_ready, result_cnt); end
        n_checks++; if (rd_data !== {1'b0, 32'd100}) begin n_fail++; $display("FAIL bp_head: got %h want %h", rd_data, {1'b0, 32'd100}); end
        rd_en = 1'b1;
        #2;
        n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_no_early_ready: got %b want 0", in_ready); end
        tick();
        rd_en = 1'b0;
        n_checks++; if (in_ready !== 1'b1 || fifo_count !== 4'd7) begin
            n_fail++; $display("FAIL bp_ready_after_pop: got rdy %b fifo %0d want 1/7", in_ready, fifo_count); end
        tick();
        in_valid = 1'b0;
        n_checks++; if (fifo_count !== 4'd8 || result_cnt !== 16'd9) begin
            n_fail++; $display("FAIL bp_stalled_beat: got fifo %0d cnt %0d want 8/9", fifo_count, result_cnt); end
        for (int i = 0; i < 8; i++) begin
            want = {1'b0, 32'(101 + i)};
            n_checks++; if (rd_data !== want) begin n_fail++; $display("FAIL bp_drain_%0d: got %h want %h", i, rd_data, want); end
            rd_en = 1'b1; tick(); rd_en = 1'b0;
        end
        n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL bp_empty: got rd_valid %b want 0", rd_valid); end
    endtask

    task automatic test_push_pop_same();
        logic [32:0] want;
        do_start(16'd20);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; outputs = 32'hA0 + 32'(i); tick();
        end
        outputs = 32'hA3; rd_en = 1'b1;
        tick();
        in_valid = 1'b0; rd_en = 1'b0;
        n_checks++; if (fifo_count !== 4'd3) begin n_fail++; $display("FAIL pp_count: got %0d want 3", fifo_count); end
        for (int i = 1; i < 4; i++) begin
            want = {1'b0, 32'hA0 + 32'(i)};
            n_checks++; if (rd_data !== want) begin n_fail++; $display("FAIL pp_order_%0d: got %h want %h", i, rd_data, want); end
            rd_en = 1'b1; tick(); rd_en = 1'b0;
        end
    endtask

    task automatic test_wrap();
        logic [32:0] want;
        do_start(16'd12);
        for (int i = 0; i < 12; i++) begin
            in_valid = 1'b1; outputs = 32'hC0 + 32'(i); zero = (i == 1 || i == 4);
            rd_en = rd_valid;
            if (rd_valid) begin
                want = {(i - 1 == 1 || i - 1 == 4), 32'hC0 + 32'(i - 1)};
                n_checks++; if (rd_data !== want) begin n_fail++; $display("FAIL wrap_data_%0d: got %h want %h", i - 1, rd_data, want); end
            end
            tick();
        end
        in_valid = 1'b0; zero = 1'b0; rd_en = 1'b0;
        n_checks++; if (rd_data !== {1'b0, 32'hCB}) begin n_fail++; $display("FAIL wrap_last: got %h want %h", rd_data, {1'b0, 32'hCB}); end
        rd_en = 1'b1; tick(); rd_en = 1'b0;
        n_checks++; if (zero_cnt !== 16'd2 || result_cnt !== 16'd12 || done !== 1'b1 || fifo_count !== 4'd0) begin
            n_fail++; $display("FAIL wrap_totals: got z %0d cnt %0d done %b fifo %0d want 2/12/1/0", zero_cnt, result_cnt, done, fifo_count); end
    endtask

    task automatic test_underflow();
        rd_en = 1'b1; tick(); rd_en = 1'b0;
        n_checks++; if (underflow !== 1'b1 || fifo_count !== 4'd0 || rd_data !== 33'd0) begin
            n_fail++; $display("FAIL uf_set: got uf %b fifo %0d data %h want 1/0/0", underflow, fifo_count, rd_data); end
        tick();
        n_checks++; if (underflow !== 1'b1) begin n_fail++; $display("FAIL uf_sticky: got %b want 1", underflow); end
    endtask

    task automatic test_zero_expected();
        do_start(16'd0);
        n_checks++; if (underflow !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL zexp_start: got uf %b done %b want 0/0", underflow, done); end
        tick();
        n_checks++; if (done !== 1'b1 || result_cnt !== 16'd0 || in_ready !== 1'b0) begin
            n_fail++; $display("FAIL zexp_done: got done %b cnt %0d rdy %b want 1/0/0", done, result_cnt, in_ready); end
    endtask

    task automatic test_reset_mid();
        do_start(16'd10);
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; outputs = 32'h55 + 32'(i); zero = 1'b1; tick();
        end
        in_valid = 1'b0; zero = 1'b0;
        n_checks++; if (result_cnt !== 16'd3 || zero_cnt !== 16'd3 || fifo_count !== 4'd3) begin
            n_fail++; $display("FAIL mid_pre: got %0d/%0d/%0d want 3/3/3", result_cnt, zero_cnt, fifo_count); end
        RST = 1'b1; tick(); RST = 1'b0;
        n_checks++; if (result_cnt !== 16'd0 || zero_cnt !== 16'd0 || fifo_count !== 4'd0 || rd_valid !== 1'b0) begin
            n_fail++; $display("FAIL mid_counts: got %0d/%0d/%0d v %b want 0/0/0 v 0", result_cnt, zero_cnt, fifo_count, rd_valid); end
        n_checks++; if (signature !== 32'hFFFFFFFF || rd_data !== 33'd0 || in_ready !== 1'b0 || done !== 1'b0) begin
            n_fail++; $display("FAIL mid_state: got sig %h data %h rdy %b done %b want ffffffff/0/0/0", signature, rd_data, in_ready, done); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_push_pop_same();
        test_wrap();
        test_underflow();
        test_zero_expected();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
